// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// The aluop values are also consumed by the ALU decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    BEQEX, IMMEX, IMMWB, JEX, ILLEGAL
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_FUNCT = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
  } ctrl_t;

  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_SLTI: imm_aluop = ALU_SLT;
      OP_ORI:  imm_aluop = ALU_OR;
      OP_LUI:  imm_aluop = ALU_LUI;
      default: imm_aluop = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational control-output decode from (state, op, zero, mem_ready).
// FETCH irwrite/pcen and BEQEX pcen are Mealy terms.
module mc_outdec
  import mc_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_op,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctl
);

  always_comb begin
    o_ctl = '0;
    case (i_state)
      FETCH: begin
        o_ctl.memread = 1'b1;
        o_ctl.alusrcb = SRCB_4;
        o_ctl.irwrite = i_mem_ready;
        o_ctl.pcen    = i_mem_ready;
      end
      DECODE: o_ctl.alusrcb = SRCB_IMMSH;
      MEMADR: begin
        o_ctl.alusrca = 1'b1;
        o_ctl.alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        o_ctl.memread = 1'b1;
        o_ctl.iord    = 1'b1;
      end
      MEMWB: begin
        o_ctl.regwrite = 1'b1;
        o_ctl.memtoreg = 1'b1;
      end
      MEMWR: begin
        o_ctl.memwrite = 1'b1;
        o_ctl.iord     = 1'b1;
      end
      RTYPEEX: begin
        o_ctl.alusrca = 1'b1;
        o_ctl.aluop   = ALU_FUNCT;
      end
      RTYPEWB: begin
        o_ctl.regwrite = 1'b1;
        o_ctl.regdst   = 1'b1;
      end
      BEQEX: begin
        o_ctl.alusrca = 1'b1;
        o_ctl.aluop   = ALU_SUB;
        o_ctl.pcsrc   = PC_ALUOUT;
        o_ctl.pcen    = i_zero;
      end
      // op comes straight from the IR, which is frozen outside FETCH
      IMMEX: begin
        o_ctl.alusrca = 1'b1;
        o_ctl.alusrcb = SRCB_IMM;
        o_ctl.aluop   = imm_aluop(i_op);
        o_ctl.zeroext = (i_op == OP_ORI);
      end
      IMMWB: begin
        o_ctl.regwrite = 1'b1;
        o_ctl.zeroext  = (i_op == OP_ORI);
      end
      JEX: begin
        o_ctl.pcsrc = PC_JUMP;
        o_ctl.pcen  = 1'b1;
      end
      default: o_ctl = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: state register, next-state logic and
// sticky illegal-opcode flag. Every output is held at 0 while reset is high.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [2:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal
);

  state_t r_state;
  logic   r_illegal;
  ctrl_t  w_ctl;
  ctrl_t  w_ctl_g;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        FETCH:   if (mem_ready) r_state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW:                     r_state <= MEMADR;
            OP_R:                             r_state <= RTYPEEX;
            OP_BEQ:                           r_state <= BEQEX;
            OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: r_state <= IMMEX;
            OP_J:                             r_state <= JEX;
            default: begin
              r_state   <= ILLEGAL;
              r_illegal <= 1'b1;
            end
          endcase
        end
        MEMADR:  r_state <= (op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   if (mem_ready) r_state <= MEMWB;
        MEMWR:   if (mem_ready) r_state <= FETCH;
        RTYPEEX: r_state <= RTYPEWB;
        IMMEX:   r_state <= IMMWB;
        ILLEGAL: r_state <= ILLEGAL;
        default: r_state <= FETCH;
      endcase
    end
  end

  mc_outdec u_outdec (
    .i_state     (r_state),
    .i_op        (op),
    .i_zero      (zero),
    .i_mem_ready (mem_ready),
    .o_ctl       (w_ctl)
  );

  // Gating here means an in-flight write cannot leak out during reset
  assign w_ctl_g  = reset ? '0 : w_ctl;

  assign iord     = w_ctl_g.iord;
  assign memread  = w_ctl_g.memread;
  assign memwrite = w_ctl_g.memwrite;
  assign irwrite  = w_ctl_g.irwrite;
  assign regdst   = w_ctl_g.regdst;
  assign memtoreg = w_ctl_g.memtoreg;
  assign regwrite = w_ctl_g.regwrite;
  assign alusrca  = w_ctl_g.alusrca;
  assign alusrcb  = w_ctl_g.alusrcb;
  assign zeroext  = w_ctl_g.zeroext;
  assign aluop    = w_ctl_g.aluop;
  assign pcsrc    = w_ctl_g.pcsrc;
  assign pcen     = w_ctl_g.pcen;
  assign illegal  = r_illegal & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each cycle's expected output vector is
// queued when inputs are driven and checked at the following negedge.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, zeroext, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [17:0] exp;
  } sb_t;
  sb_t sbq[$];

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .aluop(aluop),
    .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal)
  );

  // {iord,memread,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
  //  alusrcb[1:0],zeroext,aluop[2:0],pcsrc[1:0],pcen,illegal}
  localparam logic [17:0] E_ZERO  = 18'b0_0_0_0_0_0_0_0_00_0_000_00_0_0;
  localparam logic [17:0] E_FETCH = 18'b0_1_0_1_0_0_0_0_01_0_000_00_1_0;
  localparam logic [17:0] E_FWAIT = 18'b0_1_0_0_0_0_0_0_01_0_000_00_0_0;
  localparam logic [17:0] E_DEC   = 18'b0_0_0_0_0_0_0_0_11_0_000_00_0_0;
  localparam logic [17:0] E_MADR  = 18'b0_0_0_0_0_0_0_1_10_0_000_00_0_0;
  localparam logic [17:0] E_MRD   = 18'b1_1_0_0_0_0_0_0_00_0_000_00_0_0;
  localparam logic [17:0] E_MWB   = 18'b0_0_0_0_0_1_1_0_00_0_000_00_0_0;
  localparam logic [17:0] E_MWR   = 18'b1_0_1_0_0_0_0_0_00_0_000_00_0_0;
  localparam logic [17:0] E_RX    = 18'b0_0_0_0_0_0_0_1_00_0_100_00_0_0;
  localparam logic [17:0] E_RWB   = 18'b0_0_0_0_1_0_1_0_00_0_000_00_0_0;
  localparam logic [17:0] E_BEQ1  = 18'b0_0_0_0_0_0_0_1_00_0_001_01_1_0;
  localparam logic [17:0] E_BEQ0  = 18'b0_0_0_0_0_0_0_1_00_0_001_01_0_0;
  localparam logic [17:0] E_JEX   = 18'b0_0_0_0_0_0_0_0_00_0_000_10_1_0;
  localparam logic [17:0] E_ILL   = 18'b0_0_0_0_0_0_0_0_00_0_000_00_0_1;

  function automatic logic [17:0] e_immex(input logic z, input logic [2:0] a);
    return {8'b0000_0001, 2'b10, z, a, 4'b0000};
  endfunction

  function automatic logic [17:0] e_immwb(input logic z);
    return {8'b0000_0010, 2'b00, z, 3'b000, 4'b0000};
  endfunction

  // Queue expectation for the current cycle, check at negedge, advance.
  task automatic cyc(input string tag, input logic [17:0] exp);
    sb_t         s;
    logic [17:0] obs;
    sbq.push_back('{tag, exp});
    @(negedge clk);
    obs = {iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, zeroext, aluop, pcsrc, pcen, illegal};
    s = sbq.pop_front();
    total++;
    assert (obs === s.exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", s.tag, obs, s.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic imm_instr(input string nm, input logic [5:0] o,
                           input logic z, input logic [2:0] a);
    op = o;
    cyc({nm, "_fetch"}, E_FETCH);
    cyc({nm, "_decode"}, E_DEC);
    cyc({nm, "_immex"}, e_immex(z, a));
    cyc({nm, "_immwb"}, e_immwb(z));
  endtask

  initial begin
    reset = 1'b1;
    cyc("rst0", E_ZERO);
    cyc("rst1", E_ZERO);
    reset = 1'b0;

    // sw interrupted by reset while waiting in MEMWR
    op = 6'b101011;
    cyc("sw_r_fetch", E_FETCH);
    cyc("sw_r_decode", E_DEC);
    cyc("sw_r_memadr", E_MADR);
    mem_ready = 1'b0;
    cyc("sw_r_memwr", E_MWR);
    reset = 1'b1;
    cyc("sw_r_rst0", E_ZERO);
    cyc("sw_r_rst1", E_ZERO);
    reset = 1'b0;
    mem_ready = 1'b1;

    // lw, mem_ready always high: 5 cycles
    op = 6'b100011;
    cyc("lw_fetch", E_FETCH);
    cyc("lw_decode", E_DEC);
    cyc("lw_memadr", E_MADR);
    cyc("lw_memrd", E_MRD);
    cyc("lw_memwb", E_MWB);

    // lw with fetch wait and read wait; mem_ready low in DECODE is ignored
    op = 6'b100011;
    mem_ready = 1'b0;
    cyc("lw2_fwait", E_FWAIT);
    mem_ready = 1'b1;
    cyc("lw2_fetch", E_FETCH);
    mem_ready = 1'b0;
    cyc("lw2_decode", E_DEC);
    cyc("lw2_memadr", E_MADR);
    cyc("lw2_memrd_w", E_MRD);
    mem_ready = 1'b1;
    cyc("lw2_memrd", E_MRD);
    cyc("lw2_memwb", E_MWB);

    // sw with 3 wait cycles in MEMWR
    op = 6'b101011;
    cyc("sw_fetch", E_FETCH);
    cyc("sw_decode", E_DEC);
    cyc("sw_memadr", E_MADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("sw_memwr_w", E_MWR);
    mem_ready = 1'b1;
    cyc("sw_memwr", E_MWR);

    // R-type
    op = 6'b000000;
    cyc("r_fetch", E_FETCH);
    cyc("r_decode", E_DEC);
    cyc("r_ex", E_RX);
    cyc("r_wb", E_RWB);

    // beq taken then not taken
    op = 6'b000100;
    zero = 1'b1;
    cyc("beq1_fetch", E_FETCH);
    cyc("beq1_decode", E_DEC);
    cyc("beq1_ex", E_BEQ1);
    zero = 1'b0;
    cyc("beq0_fetch", E_FETCH);
    cyc("beq0_decode", E_DEC);
    cyc("beq0_ex", E_BEQ0);

    imm_instr("ori",  6'b001101, 1'b1, 3'b011);
    imm_instr("lui",  6'b001111, 1'b0, 3'b101);
    imm_instr("slti", 6'b001010, 1'b0, 3'b010);
    imm_instr("addi", 6'b001000, 1'b0, 3'b000);

    // jump
    op = 6'b000010;
    cyc("j_fetch", E_FETCH);
    cyc("j_decode", E_DEC);
    cyc("j_ex", E_JEX);

    // illegal opcode: sticks until reset, with memory toggling
    op = 6'b111111;
    cyc("ill_fetch", E_FETCH);
    cyc("ill_decode", E_DEC);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      zero = i[1];
      cyc("ill_hold", E_ILL);
    end
    reset = 1'b1;
    mem_ready = 1'b1;
    cyc("ill_rst", E_ZERO);
    reset = 1'b0;
    op = 6'b000010;
    cyc("post_fetch", E_FETCH);
    cyc("post_decode", E_DEC);
    cyc("post_jex", E_JEX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
